// File: rtl/pose_score_pkg.sv
// Shared types and width helpers for the pose score controller and its raster counter.
package pose_score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int hwidth_f(input int hres);
        return $clog2(hres);
    endfunction

    function automatic int vwidth_f(input int vres);
        return $clog2(vres);
    endfunction

    function automatic int dwidth_f(input int hres, input int vres);
        return $clog2(hres + vres + 1);
    endfunction

endpackage

// File: rtl/pose_score_controller_raster_counter.sv
// Raster h/v/address counter: clears to the origin, steps on enable and wraps to the origin after the last pixel.
module raster_counter
    import pose_score_pkg::*;
#(
    parameter  int HRES = 320,
    parameter  int VRES = 180,
    localparam int HW   = hwidth_f(HRES),
    localparam int VW   = vwidth_f(VRES),
    localparam int AW   = $clog2(HRES * VRES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clr_in,
    input  logic          en_in,
    output logic [HW-1:0] h_out,
    output logic [VW-1:0] v_out,
    output logic [AW-1:0] addr_out,
    output logic          last_out
);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          h_end;

    assign h_end    = (h_q == HW'(HRES - 1));
    assign last_out = h_end && (v_q == VW'(VRES - 1));
    assign h_out    = h_q;
    assign v_out    = v_q;
    assign addr_out = addr_q;

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        addr_d = addr_q;
        if (clr_in || (en_in && last_out)) begin
            h_d    = '0;
            v_d    = '0;
            addr_d = '0;
        end else if (en_in) begin
            addr_d = addr_q + AW'(1);
            if (h_end) begin
                h_d = '0;
                v_d = v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/pose_score_controller.sv
// Two-phase sequencer for pixel_scorer: streams the reference pose in (LOAD), then sums tagged query distances (SCORE).
// Define SCORE_SAT_EN to make the score accumulator and pixel count saturate instead of wrapping.
module pose_score_controller
    import pose_score_pkg::*;
#(
    parameter  int HRES   = 320,
    parameter  int VRES   = 180,
    parameter  int SC_LAT = 3,
    parameter  int SWIDTH = 24,
    localparam int HWIDTH = hwidth_f(HRES),
    localparam int VWIDTH = vwidth_f(VRES),
    localparam int DWIDTH = dwidth_f(HRES, VRES),
    localparam int AWIDTH = $clog2(HRES * VRES),
    localparam int CWIDTH = $clog2(HRES * VRES + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic [AWIDTH-1:0] ref_addr_out,
    input  logic              ref_pixel_in,
    input  logic [HWIDTH-1:0] user_hcount_in,
    input  logic [VWIDTH-1:0] user_vcount_in,
    input  logic              user_valid_in,
    input  logic              user_last_in,
    output logic [HWIDTH-1:0] sc_pixel_hcount_out,
    output logic [VWIDTH-1:0] sc_pixel_vcount_out,
    output logic              sc_pixel_out,
    output logic              sc_pixel_valid_out,
    output logic [HWIDTH-1:0] sc_hcount_out,
    output logic [VWIDTH-1:0] sc_vcount_out,
    input  logic [DWIDTH-1:0] sc_distance_in,
    input  logic              sc_valid_in,
    output logic              ready_out,
    output logic              busy_out,
    output logic [SWIDTH-1:0] score_out,
    output logic [CWIDTH-1:0] count_out,
    output logic              score_valid_out
);

    localparam logic [1:0] FLUSH_LAST = 2'd2;

    state_e            state_q, state_d;
    logic              sweep_q, sweep_d;
    logic [1:0]        flush_q, flush_d;
    logic              ready_q, ready_d;
    logic              s1_vld_q, s1_vld_d;
    logic [HWIDTH-1:0] s1_h_q, s1_h_d, pix_h_q, pix_h_d, q_h_q, q_h_d;
    logic [VWIDTH-1:0] s1_v_q, s1_v_d, pix_v_q, pix_v_d, q_v_q, q_v_d;
    logic              pix_q, pix_d, pix_vld_q, pix_vld_d;
    logic [SC_LAT:0]   tag_q, tag_d;
    logic [SWIDTH-1:0] acc_q, acc_d, acc_add, score_q, score_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d, cnt_add, count_q, count_d;
    logic              score_vld_q, score_vld_d;
    logic              rc_clr, rc_en, rc_last;
    logic [HWIDTH-1:0] rc_h;
    logic [VWIDTH-1:0] rc_v;
    logic              add_en;

    raster_counter #(.HRES(HRES), .VRES(VRES)) u_sweep (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr_in   (rc_clr),
        .en_in    (rc_en),
        .h_out    (rc_h),
        .v_out    (rc_v),
        .addr_out (ref_addr_out),
        .last_out (rc_last)
    );

    // A result counts only if it lines up with one of our own queries.
    assign add_en = tag_q[SC_LAT] && sc_valid_in;

`ifdef SCORE_SAT_EN
    localparam int SUMW = ((SWIDTH > DWIDTH) ? SWIDTH : DWIDTH) + 1;
    logic [SUMW-1:0] acc_sum;
    assign acc_sum = SUMW'(acc_q) + SUMW'(sc_distance_in);
    assign acc_add = (acc_sum[SUMW-1:SWIDTH] != '0) ? '1 : acc_sum[SWIDTH-1:0];
    assign cnt_add = (cnt_q == '1) ? cnt_q : cnt_q + CWIDTH'(1);
`else
    assign acc_add = acc_q + SWIDTH'(sc_distance_in);
    assign cnt_add = cnt_q + CWIDTH'(1);
`endif

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        flush_d     = flush_q;
        ready_d     = ready_q;
        s1_vld_d    = (state_q == ST_LOAD) && sweep_q;
        s1_h_d      = rc_h;
        s1_v_d      = rc_v;
        pix_vld_d   = s1_vld_q;
        pix_d       = s1_vld_q ? ref_pixel_in : pix_q;
        pix_h_d     = s1_vld_q ? s1_h_q : pix_h_q;
        pix_v_d     = s1_vld_q ? s1_v_q : pix_v_q;
        q_h_d       = q_h_q;
        q_v_d       = q_v_q;
        tag_d       = tag_q << 1;
        acc_d       = add_en ? acc_add : acc_q;
        cnt_d       = add_en ? cnt_add : cnt_q;
        score_d     = score_q;
        count_d     = count_q;
        score_vld_d = 1'b0;
        rc_clr      = 1'b0;
        rc_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_LOAD;
                    sweep_d = 1'b1;
                    flush_d = '0;
                    rc_clr  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (sweep_q) begin
                    rc_en = 1'b1;
                    if (rc_last) sweep_d = 1'b0;
                end else if (flush_q == FLUSH_LAST) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end else begin
                    flush_d = flush_q + 2'd1;
                end
            end
            ST_READY: begin
                if (start_in) begin
                    state_d = ST_LOAD;
                    sweep_d = 1'b1;
                    flush_d = '0;
                    rc_clr  = 1'b1;
                    ready_d = 1'b0;
                    tag_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    if (user_valid_in) begin
                        q_h_d    = user_hcount_in;
                        q_v_d    = user_vcount_in;
                        tag_d[0] = 1'b1;
                    end
                    if (user_last_in) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tag_q == '0) begin
                    score_d     = acc_q;
                    count_d     = cnt_q;
                    score_vld_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            sweep_q     <= 1'b0;
            flush_q     <= '0;
            ready_q     <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_h_q      <= '0;
            s1_v_q      <= '0;
            pix_vld_q   <= 1'b0;
            pix_q       <= 1'b0;
            pix_h_q     <= '0;
            pix_v_q     <= '0;
            q_h_q       <= '0;
            q_v_q       <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            score_q     <= '0;
            count_q     <= '0;
            score_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            flush_q     <= flush_d;
            ready_q     <= ready_d;
            s1_vld_q    <= s1_vld_d;
            s1_h_q      <= s1_h_d;
            s1_v_q      <= s1_v_d;
            pix_vld_q   <= pix_vld_d;
            pix_q       <= pix_d;
            pix_h_q     <= pix_h_d;
            pix_v_q     <= pix_v_d;
            q_h_q       <= q_h_d;
            q_v_q       <= q_v_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            count_q     <= count_d;
            score_vld_q <= score_vld_d;
        end
    end

    assign sc_pixel_hcount_out = pix_h_q;
    assign sc_pixel_vcount_out = pix_v_q;
    assign sc_pixel_out        = pix_q;
    assign sc_pixel_valid_out  = pix_vld_q;
    assign sc_hcount_out       = q_h_q;
    assign sc_vcount_out       = q_v_q;
    assign ready_out           = ready_q;
    assign busy_out            = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign score_out           = score_q;
    assign count_out           = count_q;
    assign score_valid_out     = score_vld_q;

endmodule

// File: doc/pose_score_controller.md
Name: pose_score_controller

Overview:
- Sequencer in front of pixel_scorer. Runs it in two phases:
  - LOAD: raster-streams a reference skeleton from a 1-bit reference pose ROM into the scorer.
  - SCORE: forwards a user-skeleton pixel stream as scorer queries and sums the returned distances into a pose score.
- Sits between the skeleton extraction pipeline and the game/display logic.
- Guarantees the scorer never sees load and query traffic in the same cycle.

Parameters:
- HRES, 320, frame width in pixels
- VRES, 180, frame height in pixels
- SC_LAT, 3, scorer query-to-result latency in cycles
- SWIDTH, 24, score accumulator width

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- start_in  in  1  pulse: (re)load reference pose
- ref_addr_out  out  $clog2(HRES*VRES)  reference ROM address, 1-cycle read latency
- ref_pixel_in  in  1  ROM data for the address issued last cycle
- user_hcount_in  in  HWIDTH  user skeleton pixel x
- user_vcount_in  in  VWIDTH  user skeleton pixel y
- user_valid_in  in  1  user pixel is a skeleton pixel to score
- user_last_in  in  1  final user pixel of the frame (qualifies the same cycle; may arrive with user_valid_in low)
- sc_pixel_hcount_out  out  HWIDTH  scorer load x
- sc_pixel_vcount_out  out  VWIDTH  scorer load y
- sc_pixel_out  out  1  scorer load pixel
- sc_pixel_valid_out  out  1  scorer load strobe
- sc_hcount_out  out  HWIDTH  scorer query x
- sc_vcount_out  out  VWIDTH  scorer query y
- sc_distance_in  in  DWIDTH  scorer distance result
- sc_valid_in  in  1  scorer result valid
- ready_out  out  1  reference loaded, SCORE accepted
- busy_out  out  1  LOAD or DRAIN in progress
- score_out  out  SWIDTH  summed distance of last frame
- count_out  out  $clog2(HRES*VRES+1)  pixels scored in last frame
- score_valid_out  out  1  one-cycle pulse; score_out/count_out are new

Behaviour:
- Widths: HWIDTH=$clog2(HRES), VWIDTH=$clog2(VRES), DWIDTH=$clog2(HRES+VRES+1).
- Reset (async): all outputs 0; state IDLE; loaded flag cleared; accumulator and in-flight tags cleared.
- States: IDLE, LOAD, READY, DRAIN.
- IDLE:
  - start_in -> LOAD.
  - user inputs ignored.
- LOAD:
  - ref_addr_out sweeps 0..HRES*VRES-1, one address per cycle, with an h/v counter pair, h wrapping at HRES-1.
  - One cycle later, sc_pixel_{h,v}count_out, sc_pixel_out=ref_pixel_in and sc_pixel_valid_out=1 are driven registered.
  - After the last pixel, 2 further flush cycles with sc_pixel_valid_out=0 cover the scorer write pipeline.
  - Total LOAD = HRES*VRES+3 cycles from the start_in edge. Then ready_out=1 -> READY.
  - start_in and user inputs are ignored during LOAD.
- READY:
  - user_valid_in at cycle t -> sc_{h,v}count_out registered at t+1.
  - A tag bit enters an SC_LAT+1-deep shift register.
  - The accumulator adds sc_distance_in (zero-extended) only when the tag at the output stage is 1 AND sc_valid_in=1. Untagged scorer results are ignored.
  - count increments with each add.
  - user_last_in -> DRAIN; a valid pixel in that same cycle is still scored.
  - start_in in READY: ready_out drops, accumulator clears, -> LOAD; in-flight tags are discarded.
- DRAIN:
  - New user pixels are ignored; continue until the tag register is empty.
  - Then, in one cycle: score_out=accumulator, count_out=count, score_valid_out=1, accumulator and count clear, -> READY.
  - score_out/count_out hold until the next pulse.
- Arithmetic: the accumulator wraps modulo 2^SWIDTH unless SCORE_SAT_EN is defined.
- user_last_in with no scored pixels -> score 0, count 0, pulse still issued.
- busy_out=1 in LOAD and DRAIN only.

Optional Feature:
- Macro: SCORE_SAT_EN.
- Defined: accumulator and count saturate at all-ones, with no wrap.
- Undefined: plain modular addition.

Decomposition:
- Package pose_score_pkg:
  - state enum typedef (IDLE/LOAD/READY/DRAIN);
  - width localparam functions for HWIDTH/VWIDTH/DWIDTH from HRES/VRES.
- Natural sub-module: raster_counter (h/v/address counter with enable, wrap and last flag), used for the LOAD sweep.

Test Plan:
- HRES=8, VRES=4; ROM with a single 1 at (3,2); start_in -> sc_pixel_valid_out high 32 consecutive cycles starting 2 cycles after start; ready_out rises exactly 35 cycles after start.
- Scorer model returning distance=h+v; user pixels (1,1),(2,0),(5,3) then user_last_in -> score_out=2+2+8=12, count_out=3, single score_valid_out pulse.
- user_last_in only, no valid pixels -> score_out=0, count_out=0, pulse asserted.
- Scorer asserts sc_valid_in every cycle in READY with no user pixels -> accumulator stays 0 (tag gating).
- start_in mid-DRAIN is ignored; start_in in READY with 2 queries in flight -> reload, those results not summed, next frame's score excludes them.
- SWIDTH=4, distances 9+9 -> score_out=2 without SCORE_SAT_EN, 15 with it; rst_in asserted mid-LOAD -> outputs 0 immediately, ready_out stays 0 until a full reload.
